// File: rtl/edge_stream_filter.sv
// edge_stream_filter: streaming 3x3 Sobel/Prewitt gradient magnitude filter.
// Buffers two lines plus a 3x3 window. Emits one output pixel per input pixel
// in raster order, and forces border pixels to 0.
// Optional build macro EDGE_THRESH_EN adds a thresh port and binarises the
// output to 0 or all-ones.
// Ports:
//   clk, rst (async, active-low)
//   mode                         0 = Sobel, 1 = Prewitt, latched at in_sof
//   thresh                       binarise threshold (EDGE_THRESH_EN only)
//   in_valid/in_ready/in_sof/in_pixel     input stream
//   out_valid/out_ready/out_pixel         output stream
//   out_sof/out_eol/out_eof               output framing sidebands
//   busy                         a frame is in progress
module edge_stream_filter #(
  parameter int unsigned WIDTH  = 45,
  parameter int unsigned HEIGHT = 45,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned SHIFT  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
`ifdef EDGE_THRESH_EN
  input  logic [PIX_W-1:0] thresh,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             busy
);

  localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW   = $clog2(HEIGHT + 1);
  localparam int unsigned GW   = PIX_W + 4;
  localparam int unsigned MW   = PIX_W + 3;
  localparam int unsigned MAXV = (1 << PIX_W) - 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    in_col_q, in_col_d, prod_col_q, prod_col_d;
  logic [RW-1:0]    in_row_q, in_row_d, prod_row_q, prod_row_d;
  logic             mode_q, mode_d, busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
  logic             out_sof_q, out_sof_d, out_eol_q, out_eol_d, out_eof_q, out_eof_d;
`ifdef EDGE_THRESH_EN
  logic [PIX_W-1:0] thresh_q, thresh_d;
`endif

  logic [PIX_W-1:0] lb0_q [WIDTH];
  logic [PIX_W-1:0] lb1_q [WIDTH];
  logic [PIX_W-1:0] win_q  [3][3];
  logic [PIX_W-1:0] win_d  [3][3];
  logic [PIX_W-1:0] win_sh [3][3];
  logic             lb_we;

  logic in_fire, out_fire, sof_start, store, load, border;

  logic signed [GW-1:0] p [3][3];
  logic signed [GW-1:0] gx, gy, ax, ay, kl, kr, kt, kb;
  logic [MW-1:0]        mag, scaled;
  logic [PIX_W-1:0]     sat, pix_val;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  // In FLUSH, in_ready is only high while the final output is taken, so a
  // new frame can start on that same cycle.
  assign sof_start = in_fire && in_sof && (state_q == S_IDLE || state_q == S_FLUSH);
  assign store     = sof_start || (in_fire && (state_q == S_FILL || state_q == S_RUN));
  assign load      = (state_q == S_RUN && in_fire) ||
                     (state_q == S_FLUSH && (!out_valid_q || out_ready) &&
                      prod_row_q != RW'(HEIGHT));
  assign border    = (prod_row_q == '0) || (prod_row_q == RW'(HEIGHT - 1)) ||
                     (prod_col_q == '0) || (prod_col_q == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (sof_start) state_d = S_FILL;
      S_FILL:  if (in_fire && in_row_q == RW'(1) && in_col_q == '0) state_d = S_RUN;
      S_RUN:   if (in_fire && in_row_q == RW'(HEIGHT - 1) &&
                   in_col_q == CW'(WIDTH - 1)) state_d = S_FLUSH;
      S_FLUSH: begin
        if (sof_start)                   state_d = S_FILL;
        else if (out_fire && out_eof_q)  state_d = S_IDLE;
      end
    endcase
  end

  // Handshake output
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      S_IDLE, S_FILL: in_ready = 1'b1;
      S_RUN:          in_ready = !out_valid_q || out_ready;
      S_FLUSH:        in_ready = out_valid_q && out_ready && out_eof_q;
    endcase
  end

  // Window after shifting in the current input column (rows r-2, r-1, r)
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_sh[i][0] = win_q[i][1];
      win_sh[i][1] = win_q[i][2];
    end
    win_sh[0][2] = lb1_q[in_col_q];
    win_sh[1][2] = lb0_q[in_col_q];
    win_sh[2][2] = in_pixel;
  end

  // Gradient magnitude; the centre-row/column weight is 2 for Sobel, 1 for Prewitt
  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = $signed(GW'(win_sh[i][j]));
    kl = mode_q ? p[1][0] : (p[1][0] <<< 1);
    kr = mode_q ? p[1][2] : (p[1][2] <<< 1);
    kt = mode_q ? p[0][1] : (p[0][1] <<< 1);
    kb = mode_q ? p[2][1] : (p[2][1] <<< 1);
    gx = (p[0][2] + kr + p[2][2]) - (p[0][0] + kl + p[2][0]);
    gy = (p[2][0] + kb + p[2][2]) - (p[0][0] + kt + p[0][2]);
    ax = gx[GW-1] ? -gx : gx;
    ay = gy[GW-1] ? -gy : gy;
    mag    = MW'(ax) + MW'(ay);
    scaled = mag >> SHIFT;
    sat    = (scaled > MW'(MAXV)) ? PIX_W'(MAXV) : PIX_W'(scaled);
`ifdef EDGE_THRESH_EN
    pix_val = (sat >= thresh_q) ? PIX_W'(MAXV) : '0;
`else
    pix_val = sat;
`endif
  end

  // Datapath next-state: counters, latched config, output register
  always_comb begin
    in_col_d    = in_col_q;
    in_row_d    = in_row_q;
    prod_col_d  = prod_col_q;
    prod_row_d  = prod_row_q;
    mode_d      = mode_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    out_sof_d   = out_sof_q;
    out_eol_d   = out_eol_q;
    out_eof_d   = out_eof_q;
    win_d       = win_q;
    lb_we       = 1'b0;
`ifdef EDGE_THRESH_EN
    thresh_d    = thresh_q;
`endif

    if (out_fire) begin
      out_valid_d = 1'b0;
      if (out_eof_q) busy_d = 1'b0;
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_pixel_d = border ? '0 : pix_val;
      out_sof_d   = (prod_row_q == '0) && (prod_col_q == '0);
      out_eol_d   = (prod_col_q == CW'(WIDTH - 1));
      out_eof_d   = (prod_col_q == CW'(WIDTH - 1)) && (prod_row_q == RW'(HEIGHT - 1));
      if (prod_col_q == CW'(WIDTH - 1)) begin
        prod_col_d = '0;
        prod_row_d = prod_row_q + RW'(1);
      end else begin
        prod_col_d = prod_col_q + CW'(1);
      end
    end

    if (store) begin
      win_d = win_sh;
      lb_we = 1'b1;
      if (in_col_q == CW'(WIDTH - 1)) begin
        in_col_d = '0;
        in_row_d = in_row_q + RW'(1);
      end else begin
        in_col_d = in_col_q + CW'(1);
      end
    end

    if (sof_start) begin
      in_col_d   = CW'(1);
      in_row_d   = '0;
      prod_col_d = '0;
      prod_row_d = '0;
      mode_d     = mode;
      busy_d     = 1'b1;
`ifdef EDGE_THRESH_EN
      thresh_d   = thresh;
`endif
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_col_q    <= '0;
      in_row_q    <= '0;
      prod_col_q  <= '0;
      prod_row_q  <= '0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
`ifdef EDGE_THRESH_EN
      thresh_q    <= '0;
`endif
    end else begin
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      prod_col_q  <= prod_col_d;
      prod_row_q  <= prod_row_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
`ifdef EDGE_THRESH_EN
      thresh_q    <= thresh_d;
`endif
    end
  end

  // Line buffers and window hold don't-care data until refilled, so no reset
  always_ff @(posedge clk) begin
    win_q <= win_d;
    if (lb_we) begin
      lb1_q[in_col_q] <= lb0_q[in_col_q];
      lb0_q[in_col_q] <= in_pixel;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_edge_stream_filter.sv
// Directed bench for edge_stream_filter on a 5x5 frame with SHIFT=2.
module tb_edge_stream_filter;

  localparam int W = 5;
  localparam int H = 5;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_sof = 1'b0;
  logic [7:0] in_pixel = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_pixel;
  logic       out_sof, out_eol, out_eof, busy;
`ifdef EDGE_THRESH_EN
  logic [7:0] thresh = 8'd200;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edge_stream_filter #(.WIDTH(W), .HEIGHT(H), .PIX_W(8), .SHIFT(2)) dut (
    .clk(clk), .rst(rst), .mode(mode),
`ifdef EDGE_THRESH_EN
    .thresh(thresh),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // pattern 0: flat 100, 1: columns 0-1 = 0 and 2-4 = 255, 2: flat 0
  function automatic int pix_at(input int pat, input int idx);
    if (pat == 0) return 100;
    if (pat == 1) return ((idx % W) < 2) ? 0 : 255;
    return 0;
  endfunction

  // Hand-derived: step frame gives Gx=1020 (Sobel) or 765 (Prewitt) at cols 1-2
  function automatic int exp_at(input int pat, input int m, input int idx);
    int r, c, s;
    r = idx / W;
    c = idx % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    s = (pat == 1 && (c == 1 || c == 2)) ? ((m != 0) ? 191 : 255) : 0;
`ifdef EDGE_THRESH_EN
    return (s >= int'(thresh)) ? 255 : 0;
`else
    return s;
`endif
  endfunction

  // Sends one frame and collects its outputs; call at a falling edge
  task automatic run_frame(input string tag, input int pat, input int m,
                           input bit toggle, input bit rnd, input bit junk);
    int idx_in, n_out, cyc;
    bit hold;
    logic [7:0] hold_pix;
    logic [7:0] got_pix [N];
    logic       got_sof [N];
    logic       got_eol [N];
    logic       got_eof [N];
    idx_in = 0; n_out = 0; cyc = 0; hold = 1'b0; hold_pix = 8'd0;
    if (junk) begin
      in_valid = 1'b1; in_sof = 1'b0; in_pixel = 8'd77; out_ready = 1'b1;
      #1 check({tag, " junk_ready"}, in_ready, 1);
      @(negedge clk);
      #1 check({tag, " junk_discard_busy"}, busy, 0);
    end
    while (n_out < N && cyc < 2000) begin
      in_valid  = (idx_in < N) && (!rnd || $urandom_range(0, 1) == 1);
      in_sof    = (idx_in == 0);
      in_pixel  = 8'(pix_at(pat, idx_in));
      mode      = (idx_in == 0) ? m[0] : ~m[0];
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (hold) begin
        check($sformatf("%s hold_valid c%0d", tag, cyc), out_valid, 1);
        check($sformatf("%s hold_pix c%0d", tag, cyc), out_pixel, hold_pix);
      end
      if (out_valid && !out_ready) begin
        check($sformatf("%s stall_in_ready c%0d", tag, cyc), in_ready, 0);
        hold = 1'b1;
        hold_pix = out_pixel;
      end else begin
        hold = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (n_out < N) begin
          got_pix[n_out] = out_pixel;
          got_sof[n_out] = out_sof;
          got_eol[n_out] = out_eol;
          got_eof[n_out] = out_eof;
        end
        if (n_out == N - 1) check({tag, " busy_before_last"}, busy, 1);
        n_out++;
      end
      if (in_valid && in_ready) idx_in++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, " output_count"}, n_out, N);
    #1;
    check({tag, " busy_after_last"}, busy, 0);
    check({tag, " idle_out_valid"}, out_valid, 0);
    for (int i = 0; i < N && i < n_out; i++) begin
      check($sformatf("%s pix%0d", tag, i), got_pix[i], exp_at(pat, m, i));
      check($sformatf("%s sof%0d", tag, i), got_sof[i], (i == 0) ? 1 : 0);
      check($sformatf("%s eol%0d", tag, i), got_eol[i], (i % W == W - 1) ? 1 : 0);
      check($sformatf("%s eof%0d", tag, i), got_eof[i], (i == N - 1) ? 1 : 0);
    end
    @(negedge clk);
  endtask

  initial begin
    int sent, guard;
    #1 rst = 1'b0;
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst out_pixel", out_pixel, 0);
    check("rst out_sof", out_sof, 0);
    check("rst out_eol", out_eol, 0);
    check("rst out_eof", out_eof, 0);
    check("rst in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_frame("flat100", 0, 0, 1'b0, 1'b0, 1'b1);
    run_frame("sobel_step", 1, 0, 1'b0, 1'b0, 1'b0);
    run_frame("prewitt_step", 1, 1, 1'b0, 1'b0, 1'b0);
    run_frame("sobel_stall", 1, 0, 1'b1, 1'b1, 1'b0);

    // Abort a frame with reset after 12 accepted inputs
    sent = 0; guard = 0;
    out_ready = 1'b1;
    while (sent < 12 && guard < 200) begin
      in_valid = 1'b1;
      in_sof   = (sent == 0);
      in_pixel = 8'(pix_at(1, sent));
      mode     = 1'b0;
      #1;
      if (in_ready) sent++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check("abort sent", sent, 12);
    #1 check("abort pre_rst_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort busy", busy, 0);
    check("abort out_pixel", out_pixel, 0);
    check("abort out_eol", out_eol, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame("after_rst", 2, 0, 1'b0, 1'b0, 1'b0);

`ifdef EDGE_THRESH_EN
    thresh = 8'd200;
    run_frame("thr200", 1, 0, 1'b0, 1'b0, 1'b0);
    thresh = 8'd0;
    run_frame("thr0", 1, 0, 1'b0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_stream_filter.md
Name: edge_stream_filter

Overview:
- Streaming 3x3 gradient edge detector (Sobel or Prewitt, selectable per frame) for the PDF scanner pipeline.
- Accepts raster-order pixels over a valid/ready handshake and buffers two lines internally instead of the whole frame.
- Emits one output pixel per input pixel: same frame size, border pixels forced to 0.
- Sits between the grayscale/median stage and the binarise/write-back stage.

Parameters:
- WIDTH, 45, pixels per line (>=3).
- HEIGHT, 45, lines per frame (>=3).
- PIX_W, 8, bits per pixel (input and output).
- SHIFT, 3, right shift applied to the gradient magnitude before saturation.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mode  in  1  0 = Sobel, 1 = Prewitt; sampled with the first pixel of a frame.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  filter accepts a pixel this cycle.
- in_sof  in  1  marks the first pixel (row 0, col 0) of a frame.
- in_pixel  in  PIX_W  unsigned input pixel.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output.
- out_pixel  out  PIX_W  edge magnitude, or binary value when the optional feature is on.
- out_sof  out  1  first output pixel of a frame.
- out_eol  out  1  last pixel of an output line.
- out_eof  out  1  last pixel of an output frame.
- busy  out  1  high from first accepted pixel until the last output pixel is accepted.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; in/out counters cleared.
  - out_valid, out_sof, out_eol, out_eof, busy = 0; out_pixel = 0.
  - Latched mode = Sobel.
  - Line-buffer RAM is not cleared; its contents are don't-care until refilled.
- Handshake:
  - A transfer occurs when valid && ready on that cycle.
  - A held out_valid is never dropped, and its data is never changed, until out_ready.
- States:
  - IDLE: in_ready=1. Pixels without in_sof are accepted and discarded. An in_sof pixel is stored as input index 0, mode is latched, busy=1, go to FILL.
  - FILL: in_ready=1. Accept input indices 1..WIDTH. No output is produced. After index WIDTH is accepted, go to RUN.
  - RUN: in_ready = !out_valid || out_ready.
    - Each input index n >= WIDTH+1 produces output index n-(WIDTH+1) in the output register on the next cycle (latency 1 clk from accept to out_valid).
    - After input index WIDTH*HEIGHT-1 is accepted, go to FLUSH.
  - FLUSH: in_ready=0. Emit the remaining WIDTH+1 output indices (all border, value 0), each gated by out_ready.
    - When output index WIDTH*HEIGHT-1 is accepted: busy=0, go to IDLE.
    - A back-to-back frame's in_sof may be accepted in the same cycle.
- Window and border:
  - Window = two WIDTH-deep line buffers plus a 3x3 register array.
  - Output (r,c) is 0 if r=0, r=HEIGHT-1, c=0 or c=WIDTH-1. Otherwise it is computed from the window centred at (r,c).
- Arithmetic:
  - Sobel kernels: Gx = [-1 0 1; -2 0 2; -1 0 1], Gy = [-1 -2 -1; 0 0 0; 1 2 1].
  - Prewitt kernels: the same with the 2s replaced by 1s.
  - Gx and Gy are signed, PIX_W+4 bits. mag = |Gx| + |Gy|, unsigned PIX_W+3 bits.
  - out_pixel = min(mag >> SHIFT, 2^PIX_W - 1). No floating point; truncating shift.
- Sidebands: out_sof at output index 0; out_eol at every c=WIDTH-1; out_eof at index WIDTH*HEIGHT-1. All are valid only with out_valid.
- in_sof asserted in FILL/RUN is ignored; the counters are authoritative.
- mode changes mid-frame have no effect until the next in_sof.
- Reset mid-frame aborts the frame immediately. Any pending output is lost, and the next frame must start with in_sof.

Optional Feature:
- Macro EDGE_THRESH_EN.
- Defined:
  - Adds input port thresh [PIX_W-1:0].
  - out_pixel = (scaled value >= thresh) ? 2^PIX_W-1 : 0. Border pixels stay 0.
  - thresh is latched with mode at in_sof.
- Undefined: no thresh port; out_pixel is the saturated scaled magnitude.

Test Plan:
- WIDTH=HEIGHT=5, SHIFT=2, flat frame of 100, out_ready=1 -> 25 outputs, all 0; out_eol on indices 4,9,14,19,24; out_eof only on 24; busy falls after index 24.
- Same size, Sobel, columns 0-1 = 0 and 2-4 = 255 -> rows 1-3 read 0,255,255,0,0 (Gx=1020, >>2 = 255); rows 0 and 4 all 0.
- Same frame with mode=1 (Prewitt) -> rows 1-3 read 0,191,191,0,0 (Gx=765 >>2).
- Vertical-step frame with out_ready toggling 1010... and in_valid random -> output sequence identical to the out_ready=1 run; no drops or duplicates; in_ready=0 whenever out_valid && !out_ready in RUN.
- rst pulsed low after 12 inputs, then a full flat-0 frame sent -> outputs go low async; the new frame yields 25 zeros with out_sof on the first output only.
- EDGE_THRESH_EN, thresh=200, vertical step with SHIFT=2 -> interior pixels 255 at cols 1-2, 0 elsewhere; with thresh=0, all interior pixels are 255.
